// File: rtl/external_clk_pkg.sv
// Shared phase-window constants and helpers for the external clock generator.
// Phase counter is 3 bits: one M-cycle is eight CLK periods.
package external_clk_pkg;

    localparam int PH_W              = 3;
    localparam int STABLE_CYCLES_DEF = 16;

    localparam logic [PH_W-1:0] MAIN_LO  = 3'd0;
    localparam logic [PH_W-1:0] MAIN_HI  = 3'd3;
    localparam logic [PH_W-1:0] ADR_LO   = 3'd2;
    localparam logic [PH_W-1:0] ADR_HI   = 3'd5;
    localparam logic [PH_W-1:0] DATA_LO  = 3'd4;
    localparam logic [PH_W-1:0] DATA_HI  = 3'd7;
    localparam logic [PH_W-1:0] INC_LO   = 3'd1;
    localparam logic [PH_W-1:0] INC_HI   = 3'd4;
    localparam logic [PH_W-1:0] LATCH_PH = 3'd6;
    localparam logic [PH_W-1:0] PH_LAST  = 3'd7;

    function automatic logic in_win(input logic [PH_W-1:0] ph,
                                    input logic [PH_W-1:0] lo,
                                    input logic [PH_W-1:0] hi);
        return (ph >= lo) && (ph <= hi);
    endfunction

endpackage

// File: rtl/external_clk.sv
// Oscillator start-up sequencer and eight-phase clock generator.
// Every output is a flop loaded with the decode of the next internal state.
module external_clk
    import external_clk_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic CLK,
    input  logic RESET,
    output logic MAIN_CLK_P,
    output logic MAIN_CLK_N,
    output logic ADR_CLK_P,
    output logic ADR_CLK_N,
    output logic DATA_CLK_P,
    output logic DATA_CLK_N,
    output logic INC_CLK_P,
    output logic INC_CLK_N,
    output logic LATCH_CLK,
    output logic OSC_ENA,
    output logic OSC_STABLE,
    output logic CLK_ENA,
    output logic ASYNC_RESET,
    output logic SYNC_RESET
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);

    logic [PH_W-1:0] ph, ph_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            osc_ena_n, osc_stable_n, clk_ena_n, async_n, sync_n;
    logic            main_n, adr_n, data_n, inc_n, latch_n;

    always_comb begin
        ph_n         = '0;
        cnt_n        = '0;
        osc_ena_n    = 1'b0;
        osc_stable_n = 1'b0;
        clk_ena_n    = 1'b0;
        async_n      = 1'b1;
        sync_n       = 1'b1;
        if (RESET) begin
            osc_ena_n    = 1'b1;
            async_n      = 1'b0;
            // counter saturates at STABLE_MAX so OSC_STABLE can never drop
            cnt_n        = (OSC_ENA && cnt != STABLE_MAX) ? cnt + 1'b1 : cnt;
            osc_stable_n = OSC_STABLE || (cnt_n == STABLE_MAX);
            clk_ena_n    = OSC_STABLE;
            ph_n         = CLK_ENA ? ph + 1'b1 : '0;
            sync_n       = SYNC_RESET && !(CLK_ENA && ph == PH_LAST);
        end
    end

    always_comb begin
        main_n  = clk_ena_n && in_win(ph_n, MAIN_LO, MAIN_HI);
        adr_n   = clk_ena_n && in_win(ph_n, ADR_LO, ADR_HI);
        data_n  = clk_ena_n && in_win(ph_n, DATA_LO, DATA_HI);
        inc_n   = clk_ena_n && in_win(ph_n, INC_LO, INC_HI);
        latch_n = clk_ena_n && (ph_n == LATCH_PH);
    end

    always_ff @(posedge CLK) begin
        ph          <= ph_n;
        cnt         <= cnt_n;
        OSC_ENA     <= osc_ena_n;
        OSC_STABLE  <= osc_stable_n;
        CLK_ENA     <= clk_ena_n;
        ASYNC_RESET <= async_n;
        SYNC_RESET  <= sync_n;
        MAIN_CLK_P  <= main_n;
        MAIN_CLK_N  <= !main_n;
        ADR_CLK_P   <= adr_n;
        ADR_CLK_N   <= !adr_n;
        DATA_CLK_P  <= data_n;
        DATA_CLK_N  <= !data_n;
        INC_CLK_P   <= inc_n;
        INC_CLK_N   <= !inc_n;
        LATCH_CLK   <= latch_n;
    end

endmodule

// File: tb/tb_external_clk.sv
// Bench for external_clk: default and STABLE_CYCLES=4 instances share CLK/RESET,
// checked each cycle against an edges-since-release model plus literal timing pins.
module tb_external_clk;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    logic a_mp, a_mn, a_ap, a_an, a_dp, a_dn, a_ip, a_in, a_lt, a_oe, a_os, a_ce, a_ar, a_sr;
    logic b_mp, b_mn, b_ap, b_an, b_dp, b_dn, b_ip, b_in, b_lt, b_oe, b_os, b_ce, b_ar, b_sr;

    external_clk dut16 (
        .CLK(CLK), .RESET(RESET),
        .MAIN_CLK_P(a_mp), .MAIN_CLK_N(a_mn), .ADR_CLK_P(a_ap), .ADR_CLK_N(a_an),
        .DATA_CLK_P(a_dp), .DATA_CLK_N(a_dn), .INC_CLK_P(a_ip), .INC_CLK_N(a_in),
        .LATCH_CLK(a_lt), .OSC_ENA(a_oe), .OSC_STABLE(a_os), .CLK_ENA(a_ce),
        .ASYNC_RESET(a_ar), .SYNC_RESET(a_sr)
    );

    external_clk #(.STABLE_CYCLES(4)) dut4 (
        .CLK(CLK), .RESET(RESET),
        .MAIN_CLK_P(b_mp), .MAIN_CLK_N(b_mn), .ADR_CLK_P(b_ap), .ADR_CLK_N(b_an),
        .DATA_CLK_P(b_dp), .DATA_CLK_N(b_dn), .INC_CLK_P(b_ip), .INC_CLK_N(b_in),
        .LATCH_CLK(b_lt), .OSC_ENA(b_oe), .OSC_STABLE(b_os), .CLK_ENA(b_ce),
        .ASYNC_RESET(b_ar), .SYNC_RESET(b_sr)
    );

    logic [13:0] v16, v4;
    assign v16 = {a_mp, a_mn, a_ap, a_an, a_dp, a_dn, a_ip, a_in, a_lt, a_oe, a_os, a_ce, a_ar, a_sr};
    assign v4  = {b_mp, b_mn, b_ap, b_an, b_dp, b_dn, b_ip, b_in, b_lt, b_oe, b_os, b_ce, b_ar, b_sr};

    localparam logic [13:0] RST_VEC = 14'b01_01_01_01_0_000_11;

    int total = 0;
    int bad = 0;
    int n = -1;   // edges since release: -1 = reset sampled, 0 = first released edge

    // Expected outputs after edge n for a given stabilisation length s.
    function automatic logic [13:0] exp_vec(input int k, input int s);
        logic st, en, sy, mp, ap, dp, ip, lt;
        int p;
        if (k < 0) return RST_VEC;
        st = (k >= s);
        en = (k >= s + 1);
        p  = en ? (k - s - 1) % 8 : 0;
        sy = (k < s + 9);
        mp = en && p <= 3;
        ap = en && p >= 2 && p <= 5;
        dp = en && p >= 4;
        ip = en && p >= 1 && p <= 4;
        lt = en && p == 6;
        return {mp, !mp, ap, !ap, dp, !dp, ip, !ip, lt, 1'b1, st, en, 1'b0, sy};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at n=%0d", name, act, req, n);
        end
    endtask

    // Drive RESET for one edge, advance the model, sample both DUTs on the falling edge.
    task automatic step(input logic r);
        RESET = r;
        @(posedge CLK);
        n = r ? n + 1 : -1;
        @(negedge CLK);
        chk("model16", 32'(v16), 32'(exp_vec(n, 16)));
        chk("model4",  32'(v4),  32'(exp_vec(n, 4)));
    endtask

    task automatic run_release(input int edges);
        logic [7:0] sm, sa, sd, si, sl, smn, san, sdn, sin;
        logic [4:0] p, prev;
        int last [5];
        int latches;
        latches = 0;
        prev = '0;
        for (int i = 0; i < 5; i++) last[i] = -1;
        for (int e = 0; e < edges; e++) begin
            step(1'b1);
            if (e == 0)  chk("osc_ena_e0", 32'(a_oe), 32'd1);
            if (e == 0)  chk("async_e0", 32'(a_ar), 32'd0);
            if (e == 15) chk("stable_e15", 32'(a_os), 32'd0);
            if (e == 16) chk("stable_e16", 32'(a_os), 32'd1);
            if (e == 16) chk("clk_ena_e16", 32'(a_ce), 32'd0);
            if (e == 17) chk("clk_ena_e17", 32'(a_ce), 32'd1);
            if (e == 17) chk("main_e17", 32'(a_mp), 32'd1);
            if (e == 24) chk("sync_e24", 32'(a_sr), 32'd1);
            if (e == 25) chk("sync_e25", 32'(a_sr), 32'd0);
            if (e == 3)  chk("s4_stable_e3", 32'(b_os), 32'd0);
            if (e == 4)  chk("s4_stable_e4", 32'(b_os), 32'd1);
            if (e == 5)  chk("s4_clk_ena_e5", 32'(b_ce), 32'd1);
            if (e == 12) chk("s4_sync_e12", 32'(b_sr), 32'd1);
            if (e == 13) chk("s4_sync_e13", 32'(b_sr), 32'd0);
            if (e >= 17 && e <= 24) begin
                sm[24-e] = a_mp; sa[24-e] = a_ap; sd[24-e] = a_dp; si[24-e] = a_ip; sl[24-e] = a_lt;
                smn[24-e] = a_mn; san[24-e] = a_an; sdn[24-e] = a_dn; sin[24-e] = a_in;
            end
            if (e == 24) begin
                chk("seq_main", 32'(sm), 32'h00F0);
                chk("seq_adr",  32'(sa), 32'h003C);
                chk("seq_data", 32'(sd), 32'h000F);
                chk("seq_inc",  32'(si), 32'h0078);
                chk("seq_latch", 32'(sl), 32'h0002);
                chk("seq_main_n", 32'(smn), 32'h000F);
                chk("seq_adr_n",  32'(san), 32'h00C3);
                chk("seq_data_n", 32'(sdn), 32'h00F0);
                chk("seq_inc_n",  32'(sin), 32'h0087);
            end
            p = {a_mp, a_ap, a_dp, a_ip, a_lt};
            for (int i = 0; i < 5; i++) begin
                if (p[i] && !prev[i]) begin
                    if (last[i] >= 0) chk($sformatf("period%0d", i), 32'(e - last[i]), 32'd8);
                    last[i] = e;
                end
            end
            prev = p;
            if (a_lt) latches++;
        end
        if (edges == 1000) chk("latch_count", 32'(latches), 32'd123);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) step(1'b0);
        chk("reset16", 32'(v16), 32'(RST_VEC));
        chk("reset4",  32'(v4),  32'(RST_VEC));

        run_release(1000);

        // reset mid-run at ph=5 (edge 22), then the start-up must repeat exactly
        step(1'b0);
        run_release(23);
        chk("ph5_main", 32'(a_mp), 32'd0);
        chk("ph5_data", 32'(a_dp), 32'd1);
        step(1'b0);
        chk("ph5_reset", 32'(v16), 32'(RST_VEC));
        run_release(40);

        for (int it = 0; it < 25; it++) begin
            int run_len, rst_len;
            run_len = $urandom_range(0, 60);
            rst_len = $urandom_range(1, 3);
            for (int i = 0; i < run_len; i++) step(1'b1);
            for (int i = 0; i < rst_len; i++) step(1'b0);
        end
        run_release(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
